seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter REFRESH_HZ, default 1000, per-digit scan rate; DIV = CLK_HZ/REFRESH_HZ SHALL be >= 4.
REQ-003 Parameter BLANK_CYCLES, default 2, anti-ghost blanking cycles per digit change; SHALL be < DIV.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 load  input  1  single-cycle strobe: capture data_in and dp_in.
REQ-007 data_in  input  16  four hex nibbles; digit k = data_in[4k+3:4k].
REQ-008 dp_in  input  4  decimal point per digit, active-high.
REQ-009 sel  output  2  current digit index; drives the downstream 4:1 digit mux select.
REQ-010 an  output  4  anode enables, active-low one-hot.
REQ-011 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-012 dp  output  1  decimal-point cathode, active-low.
REQ-013 frame_tick  output  1  one-cycle pulse at each sel wrap 3->0.

Function
REQ-014 Prescaler counts 0..DIV-1, wraps to 0; scan tick asserted when count == DIV-1.
REQ-015 On scan tick, sel increments mod 4 at the same edge; 3->0 wrap asserts frame_tick for exactly that following cycle.
REQ-016 On every sel change, blank counter loads BLANK_CYCLES; while nonzero it decrements each cycle and an SHALL be 4'b1111.
REQ-017 Outside blanking, an[sel] = 0, all other bits 1.
REQ-018 seg/dp SHALL decode display-register nibble and dp bit selected by sel; an, seg, dp registered, one cycle after sel/blank state, mutually aligned.
REQ-019 Hex decode: 0->1000000, 1->1111001, 8->0000000, A->0001000, F->0001110; all 16 codes standard.
REQ-020 load captures data_in/dp_in into shadow register and sets pending at the next edge.
REQ-021 At the 3->0 wrap edge, if pending, display register <= shadow and pending clears; display register otherwise never changes (no mid-frame tearing).
REQ-022 load coincident with wrap tick: wrap transfers the prior shadow; new capture stays pending for the next frame.
REQ-023 Repeated loads within one frame: last one wins.

Reset
REQ-024 On rst: prescaler 0, sel 0, blank counter BLANK_CYCLES, shadow/display 0, pending 0, an 4'b1111, seg 7'h7F, dp 1, frame_tick 0.
REQ-025 rst mid-frame or with pending load: all state returns to reset values at the next edge; pending data discarded.
REQ-026 After rst release, digit 0 shows "0" (seg 1000000) once blanking expires.

Configuration
REQ-027 Macro SEG_LEADING_ZERO_BLANK_EN defined: digits above the most-significant nonzero display nibble output seg 7'h7F and dp 1 (an timing unchanged); digit 0 always shown.
REQ-028 Macro undefined: all four digits always decoded.

Structure
REQ-029 Package seg_disp_pkg holds segment code constants, SEG_OFF (7'h7F), AN_OFF (4'hF), digit-index typedef (2-bit).
REQ-030 Sub-module hex7seg: combinational 4-bit nibble to 7-bit active-low segment decoder, instantiated once.

Verification (CLK_HZ=400, REFRESH_HZ=100 -> DIV=4, BLANK_CYCLES=1)
REQ-031 rst 3 cycles, release -> an 4'b1111 one cycle, then an 4'b1110, seg 1000000; sel steps 0,1,2,3,0 every 4 cycles; frame_tick once per 16 cycles.
REQ-032 load data_in=16'hA981 mid-frame -> display unchanged until wrap; next frame digits 0..3 show 1,8,9,A codes.
REQ-033 load 16'h1234 on wrap-tick cycle -> that frame still shows old value; 16'h1234 appears the following frame.
REQ-034 Two loads (16'h1111 then 16'h2222) in one frame -> only 2222 displayed.
REQ-035 rst asserted with pending load at sel=2 -> next edge all outputs at reset values; after release display shows 0000.
REQ-036 SEG_LEADING_ZERO_BLANK_EN defined, data 16'h0050 -> digits 3 and 2 seg 7'h7F; digit 1 "5", digit 0 "0".

Source files
------------

// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared constants and types for the seven-segment scan driver.
//   digit_idx_t    : 2-bit digit index (0 = rightmost digit)
//   SEG_OFF/AN_OFF : all-dark cathode/anode patterns (active-low)
//   SEG_0..SEG_F   : active-low {g,f,e,d,c,b,a} codes for each hex digit
//   an_onehot()    : active-low one-hot anode pattern for a digit index
package seg_disp_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    function automatic logic [3:0] an_onehot(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex nibble to active-low seven-segment decoder.
//   nibble : 4-bit hex value
//   seg    : active-low cathodes {g,f,e,d,c,b,a}
module hex7seg
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: four-digit multiplexed seven-segment display driver.
// A prescaler steps the digit select once every CLK_HZ/REFRESH_HZ cycles; after
// each digit change the anodes stay dark for BLANK_CYCLES to avoid ghosting.
// New values are loaded into a shadow register and only reach the display at
// the frame boundary (sel 3->0), so a frame never shows a mix of two values.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to darken leading zeros.
//   clk, rst   : clock, synchronous active-high reset
//   load       : strobe capturing data_in/dp_in into the shadow register
//   data_in    : four hex digits, digit k = data_in[4k+3:4k]
//   dp_in      : decimal point per digit, active-high
//   sel        : current digit index (downstream digit mux select)
//   an         : anode enables, active-low one-hot
//   seg, dp    : cathodes {g,f,e,d,c,b,a} and decimal point, active-low
//   frame_tick : one-cycle pulse after each sel 3->0 wrap
// Requires CLK_HZ/REFRESH_HZ >= 4 and BLANK_CYCLES < CLK_HZ/REFRESH_HZ.
module seg_scan_driver
    import seg_disp_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned REFRESH_HZ   = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned DIV = CLK_HZ / REFRESH_HZ;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW  = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(DIV - 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    digit_idx_t    sel_q, sel_d;
    logic [BW-1:0] blank_q, blank_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic          pending_q, pending_d;
    logic [15:0]   disp_q, disp_d;
    logic [3:0]    disp_dp_q, disp_dp_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_q, frame_d;

    logic          scan_tick;
    logic          wrap;
    logic [3:0]    cur_nibble;
    logic [6:0]    dec_seg;
    logic          digit_on;

    assign scan_tick  = (cnt_q == CNT_MAX);
    assign wrap       = scan_tick && (sel_q == 2'd3);
    assign cur_nibble = disp_q[{sel_q, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Highest nonzero digit; digit 0 is always lit even for an all-zero value.
    digit_idx_t msd;

    always_comb begin
        msd = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (disp_q[4*i +: 4] != 4'h0) begin
                msd = digit_idx_t'(i);
            end
        end
    end

    assign digit_on = (sel_q <= msd);
`else
    assign digit_on = 1'b1;
`endif

    always_comb begin
        cnt_d = scan_tick ? '0 : cnt_q + CW'(1);
        sel_d = scan_tick ? sel_q + 2'd1 : sel_q;

        // Blanking restarts on every digit change, otherwise counts down to 0.
        if (scan_tick) begin
            blank_d = BLANK_LOAD;
        end else if (blank_q != '0) begin
            blank_d = blank_q - BW'(1);
        end else begin
            blank_d = blank_q;
        end

        shadow_d    = load ? data_in : shadow_q;
        shadow_dp_d = load ? dp_in   : shadow_dp_q;

        // A load on the wrap edge wins over the clear: the transfer uses the
        // older shadow and the new capture waits for the next frame.
        disp_d    = disp_q;
        disp_dp_d = disp_dp_q;
        pending_d = pending_q;
        if (wrap && pending_q) begin
            disp_d    = shadow_q;
            disp_dp_d = shadow_dp_q;
            pending_d = 1'b0;
        end
        if (load) begin
            pending_d = 1'b1;
        end

        // Output stage decodes the current sel/blank state one cycle late.
        an_d    = (blank_q != '0) ? AN_OFF : an_onehot(sel_q);
        seg_d   = digit_on ? dec_seg : SEG_OFF;
        dp_d    = digit_on ? ~disp_dp_q[sel_q] : 1'b1;
        frame_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            sel_q       <= 2'd0;
            blank_q     <= BLANK_LOAD;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pending_q   <= 1'b0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            blank_q     <= blank_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pending_q   <= pending_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            frame_q     <= frame_d;
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed self-checking bench for seg_scan_driver with
// CLK_HZ=400, REFRESH_HZ=100 (4-cycle digit period), BLANK_CYCLES=1.
// k counts rising edges since reset release; the digit s of frame f is stable
// on the outputs at k = 16f + 4s + 2.
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    seg_scan_driver #(
        .CLK_HZ       (400),
        .REFRESH_HZ   (100),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .sel        (sel),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic go(input int target);
        if (target > k) adv(target - k);
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        data_in = d;
        dp_in   = p;
        load    = 1'b1;
        adv(1);
        load    = 1'b0;
    endtask

    task automatic digit(input string tag, input int f, input int s,
                         input logic [6:0] exp_seg, input logic exp_dp);
        logic [3:0] exp_an;
        exp_an = 4'hF;
        exp_an[s] = 1'b0;
        go(16 * f + 4 * s + 2);
        chk({tag, "_an"}, 16'(an), 16'(exp_an));
        chk({tag, "_seg"}, 16'(seg), 16'(exp_seg));
        chk({tag, "_dp"}, 16'(dp), 16'(exp_dp));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_an"}, 16'(an), 16'h000F);
        chk({tag, "_seg"}, 16'(seg), 16'h007F);
        chk({tag, "_dp"}, 16'(dp), 16'h0001);
        chk({tag, "_ft"}, 16'(frame_tick), 16'h0000);
        chk({tag, "_sel"}, 16'(sel), 16'h0000);
    endtask

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        data_in = 16'h0000;
        dp_in   = 4'h0;

        // Reset and scan timing
        adv(3);
        chk_reset("rst");
        rst = 1'b0;
        k = 0;
        go(1);
        chk("rel_an_blank", 16'(an), 16'h000F);
        chk("rel_sel0", 16'(sel), 16'h0000);
        go(2);
        chk("rel_an0", 16'(an), 16'h000E);
        chk("rel_seg0", 16'(seg), 16'h0040);
        chk("rel_dp0", 16'(dp), 16'h0001);
        go(4);
        chk("sel1", 16'(sel), 16'h0001);
        go(5);
        chk("an_blank_d1", 16'(an), 16'h000F);
        go(8);
        chk("sel2", 16'(sel), 16'h0002);
        go(12);
        chk("sel3", 16'(sel), 16'h0003);
        go(15);
        chk("ft_before", 16'(frame_tick), 16'h0000);
        go(16);
        chk("ft_wrap", 16'(frame_tick), 16'h0001);
        chk("sel_wrap", 16'(sel), 16'h0000);
        go(17);
        chk("ft_after", 16'(frame_tick), 16'h0000);

        // Mid-frame load held back until the wrap
        pulse_load(16'hA981, 4'b0101);
        digit("mid_d1", 1, 1, 7'b1000000, 1'b1);
        digit("mid_d3", 1, 3, 7'b1000000, 1'b1);
        digit("a981_d0", 2, 0, 7'b1111001, 1'b0);
        digit("a981_d1", 2, 1, 7'b0000000, 1'b1);
        digit("a981_d2", 2, 2, 7'b0010000, 1'b0);
        digit("a981_d3", 2, 3, 7'b0001000, 1'b1);

        // Load on the wrap-tick cycle: 5555 goes out, 1234 waits a frame
        pulse_load(16'h5555, 4'b0000);
        chk("pre_wrap_k", 16'(sel), 16'h0003);
        pulse_load(16'h1234, 4'b0000);
        chk("ft_wrap2", 16'(frame_tick), 16'h0001);
        digit("w5_d0", 3, 0, 7'b0010010, 1'b1);
        digit("w5_d3", 3, 3, 7'b0010010, 1'b1);
        digit("w1234_d0", 4, 0, 7'b0011001, 1'b1);

        // Two loads in one frame: last wins
        pulse_load(16'h1111, 4'b0000);
        go(70);
        pulse_load(16'h2222, 4'b0000);
        digit("w1234_d3", 4, 3, 7'b1111001, 1'b1);
        digit("w2222_d0", 5, 0, 7'b0100100, 1'b1);
        digit("w2222_d2", 5, 2, 7'b0100100, 1'b1);

        // Reset with a pending load at sel=2
        pulse_load(16'h9999, 4'b1111);
        chk("pend_sel2", 16'(sel), 16'h0002);
        rst = 1'b1;
        adv(1);
        chk_reset("rst_mid");
        rst = 1'b0;
        k = 0;
        digit("post_d0", 0, 0, 7'b1000000, 1'b1);
        digit("post_f1_d0", 1, 0, 7'b1000000, 1'b1);
        digit("post_f1_d3", 1, 3, 7'b1000000, 1'b1);

        // Leading-zero handling
        pulse_load(16'h0050, 4'b1111);
        digit("lz_d0", 2, 0, 7'b1000000, 1'b0);
        digit("lz_d1", 2, 1, 7'b0010010, 1'b0);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        digit("lz_d2", 2, 2, 7'h7F, 1'b1);
        digit("lz_d3", 2, 3, 7'h7F, 1'b1);
`else
        digit("lz_d2", 2, 2, 7'b1000000, 1'b0);
        digit("lz_d3", 2, 3, 7'b1000000, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
